// File: rtl/vector_line_ctrl.sv
// Vector display line sequencer: accepts one segment command, blanks and settles at the
// start point, then walks the segment with Bresenham stepping at a fixed per-point dwell.
module vector_line_ctrl #(
  parameter int DAC_WIDTH     = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int STEP_DIV      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DAC_WIDTH-1:0] cmd_x0,
  input  logic [DAC_WIDTH-1:0] cmd_y0,
  input  logic [DAC_WIDTH-1:0] cmd_x1,
  input  logic [DAC_WIDTH-1:0] cmd_y1,
  output logic [DAC_WIDTH-1:0] dac_x,
  output logic [DAC_WIDTH-1:0] dac_y,
  output logic                 beam_on,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MOVE   = 2'd1;
  localparam logic [1:0] ST_DRAW   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam int CNT_MAX = (SETTLE_CYCLES > STEP_DIV) ? SETTLE_CYCLES : STEP_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int EW      = DAC_WIDTH + 2;

  localparam logic [CNT_W-1:0]     SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     STEP_LOAD   = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0]     ONE_C       = CNT_W'(1);
  localparam logic [DAC_WIDTH-1:0] ONE_D       = DAC_WIDTH'(1);

  logic [1:0]            state;
  logic [DAC_WIDTH-1:0]  end_x, end_y;
  logic signed [EW-1:0]  dx_r, dy_r, err_r;
  logic                  sx_neg, sy_neg;
  logic [CNT_W-1:0]      cnt;

  // Segment setup terms, evaluated straight from the command inputs at accept
  logic signed [EW-1:0]  cx0, cy0, cx1, cy1, dx_c, dy_c, adx, ady;
  logic                  at_start, at_end;

  always_comb begin
    cx0  = {2'b00, cmd_x0};
    cy0  = {2'b00, cmd_y0};
    cx1  = {2'b00, cmd_x1};
    cy1  = {2'b00, cmd_y1};
    dx_c = cx1 - cx0;
    dy_c = cy1 - cy0;
    adx  = (dx_c < 0) ? -dx_c : dx_c;
    ady  = (dy_c < 0) ? -dy_c : dy_c;
    at_start = (cmd_x0 == dac_x) && (cmd_y0 == dac_y);
    at_end   = (dac_x == end_x) && (dac_y == end_y);
  end

  // Per-step Bresenham decision; both axis tests use the pre-step e2
  logic signed [EW:0]    e2, dx_e, dy_e;
  logic                  step_x, step_y;
  logic signed [EW-1:0]  add_dx, add_dy, err_next;
  logic [DAC_WIDTH-1:0]  next_x, next_y;

  always_comb begin
    e2       = {err_r, 1'b0};
    dx_e     = {dx_r[EW-1], dx_r};
    dy_e     = {dy_r[EW-1], dy_r};
    step_x   = (e2 >= dy_e);
    step_y   = (e2 <= dx_e);
    add_dy   = step_x ? dy_r : '0;
    add_dx   = step_y ? dx_r : '0;
    err_next = err_r + add_dy + add_dx;
    next_x   = dac_x;
    next_y   = dac_y;
    if (step_x) next_x = sx_neg ? (dac_x - ONE_D) : (dac_x + ONE_D);
    if (step_y) next_y = sy_neg ? (dac_y - ONE_D) : (dac_y + ONE_D);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      dac_x   <= '0;
      dac_y   <= '0;
      beam_on <= 1'b0;
      end_x   <= '0;
      end_y   <= '0;
      dx_r    <= '0;
      dy_r    <= '0;
      err_r   <= '0;
      sx_neg  <= 1'b0;
      sy_neg  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            end_x  <= cmd_x1;
            end_y  <= cmd_y1;
            dac_x  <= cmd_x0;
            dac_y  <= cmd_y0;
            dx_r   <= adx;
            dy_r   <= -ady;
            err_r  <= adx - ady;
            sx_neg <= (cmd_x1 < cmd_x0);
            sy_neg <= (cmd_y1 < cmd_y0);
            if (at_start) begin
              state   <= ST_DRAW;
              beam_on <= 1'b1;
              cnt     <= STEP_LOAD;
            end else begin
              state   <= ST_MOVE;
              beam_on <= 1'b0;
              cnt     <= SETTLE_LOAD;
            end
          end
        end
        ST_MOVE: begin
          if (cnt == '0) begin
            state   <= ST_DRAW;
            beam_on <= 1'b1;
            cnt     <= STEP_LOAD;
          end else begin
            cnt <= cnt - ONE_C;
          end
        end
        ST_DRAW: begin
          if (cnt == '0) begin
            if (at_end) begin
              state   <= ST_FINISH;
              beam_on <= 1'b0;
            end else begin
              cnt   <= STEP_LOAD;
              dac_x <= next_x;
              dac_y <= next_y;
              err_r <= err_next;
            end
          end else begin
            cnt <= cnt - ONE_C;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FINISH);

endmodule

// File: tb/tb_vector_line_ctrl.sv
// Directed bench for vector_line_ctrl: per-cycle traces of each segment against
// hand-derived point lists and cycle counts (SETTLE=16, STEP_DIV=4).
module tb_vector_line_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [7:0] dac_x, dac_y;
  logic       beam_on, busy, done;

  int checks = 0;
  int errors = 0;
  int px[0:7];
  int py[0:7];

  vector_line_ctrl #(
    .DAC_WIDTH(8),
    .SETTLE_CYCLES(16),
    .STEP_DIV(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0),
    .cmd_y0(cmd_y0),
    .cmd_x1(cmd_x1),
    .cmd_y1(cmd_y1),
    .dac_x(dac_x),
    .dac_y(dac_y),
    .beam_on(beam_on),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, " dac_x"},     {8'd0, dac_x}, 16'd0);
    check({tag, " dac_y"},     {8'd0, dac_y}, 16'd0);
    check({tag, " beam_on"},   {15'd0, beam_on}, 16'd0);
    check({tag, " busy"},      {15'd0, busy}, 16'd0);
    check({tag, " cmd_ready"}, {15'd0, cmd_ready}, 16'd1);
    check({tag, " done"},      {15'd0, done}, 16'd0);
  endtask

  task automatic set_cmd(input int x0, input int y0, input int x1, input int y1);
    cmd_x0 = 8'(x0);
    cmd_y0 = 8'(y0);
    cmd_x1 = 8'(x1);
    cmd_y1 = 8'(y1);
  endtask

  // Called at a negedge with cmd_valid already high in IDLE; traces every cycle up to
  // and including the IDLE cycle where cmd_ready returns. At cycle E+1 the command
  // inputs are replaced by the next command and cmd_valid is set to keep_valid.
  task automatic run_seg(input string tag, input bit has_move, input int sx, input int sy,
                         input int n, input bit keep_valid,
                         input int nx0, input int ny0, input int nx1, input int ny1);
    int m;
    int total;
    int idx;
    int ex, ey, eb, ed, er;
    m     = has_move ? 16 : 0;
    total = m + n * 4 + 2;
    @(posedge clk);
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_valid = keep_valid;
        set_cmd(nx0, ny0, nx1, ny1);
      end
      if (k <= m) begin
        ex = sx; ey = sy; eb = 0;
      end else if (k <= m + n * 4) begin
        idx = (k - m - 1) / 4;
        ex = px[idx]; ey = py[idx]; eb = 1;
      end else begin
        ex = px[n-1]; ey = py[n-1]; eb = 0;
      end
      ed = (k == total - 1) ? 1 : 0;
      er = (k == total) ? 1 : 0;
      check($sformatf("%s E+%0d dac_x", tag, k), {8'd0, dac_x}, 16'(ex));
      check($sformatf("%s E+%0d dac_y", tag, k), {8'd0, dac_y}, 16'(ey));
      check($sformatf("%s E+%0d beam_on", tag, k), {15'd0, beam_on}, 16'(eb));
      check($sformatf("%s E+%0d done", tag, k), {15'd0, done}, 16'(ed));
      check($sformatf("%s E+%0d cmd_ready", tag, k), {15'd0, cmd_ready}, 16'(er));
      check($sformatf("%s E+%0d busy", tag, k), {15'd0, busy}, 16'(1 - er));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    set_cmd(0, 0, 0, 0);
    #1;
    check_idle_reset("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_reset("post_reset");

    // Steep segment right after reset: start equals (0,0), MOVE skipped, ready at E+26
    px[0:5] = '{0, 0, 1, 1, 2, 2};
    py[0:5] = '{0, 1, 2, 3, 4, 5};
    set_cmd(0, 0, 2, 5);
    cmd_valid = 1'b1;
    run_seg("steep", 1'b0, 0, 0, 6, 1'b0, 0, 0, 0, 0);

    rst_n = 1'b0;
    #1;
    check_idle_reset("reset2");
    @(negedge clk);
    rst_n = 1'b1;

    // Horizontal from (0,0): MOVE at (10,20), done at E+33, ready at E+34
    px[0:3] = '{10, 11, 12, 13};
    py[0:3] = '{20, 20, 20, 20};
    set_cmd(10, 20, 13, 20);
    cmd_valid = 1'b1;
    run_seg("horiz", 1'b1, 10, 20, 4, 1'b0, 0, 0, 0, 0);

    // Reverse direction
    px[0:3] = '{200, 199, 198, 197};
    py[0:3] = '{100, 100, 100, 100};
    set_cmd(200, 100, 197, 100);
    cmd_valid = 1'b1;
    run_seg("reverse", 1'b1, 200, 100, 4, 1'b0, 0, 0, 0, 0);

    // Zero length at the top corner: done at E+21, ready at E+22
    px[0] = 255;
    py[0] = 255;
    set_cmd(255, 255, 255, 255);
    cmd_valid = 1'b1;
    run_seg("zero_len", 1'b1, 255, 255, 1, 1'b0, 0, 0, 0, 0);

    // Chaining with cmd_valid held high; second segment starts at the first's end
    px[0:3] = '{5, 6, 7, 8};
    py[0:3] = '{5, 5, 5, 5};
    set_cmd(5, 5, 8, 5);
    cmd_valid = 1'b1;
    run_seg("chain1", 1'b1, 5, 5, 4, 1'b1, 8, 5, 8, 7);
    px[0:2] = '{8, 8, 8};
    py[0:2] = '{5, 6, 7};
    run_seg("chain2", 1'b0, 8, 5, 3, 1'b0, 8, 7, 8, 7);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("chain_no_third busy %0d", k), {15'd0, busy}, 16'd0);
      check($sformatf("chain_no_third dac_y %0d", k), {8'd0, dac_y}, 16'd7);
    end

    // Reset during the third point of (8,7)->(8,12), which skips MOVE
    set_cmd(8, 7, 8, 12);
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_draw dac_y", {8'd0, dac_y}, 16'd9);
    check("mid_draw beam_on", {15'd0, beam_on}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_reset("mid_reset");
    repeat (2) begin
      @(negedge clk);
      check("mid_reset held done", {15'd0, done}, 16'd0);
      check("mid_reset held dac_y", {8'd0, dac_y}, 16'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_reset("after_release");

    // New command after reset starts at (0,0): MOVE skipped, old segment not resumed
    px[0:1] = '{0, 1};
    py[0:1] = '{0, 1};
    set_cmd(0, 0, 1, 1);
    cmd_valid = 1'b1;
    run_seg("post_abort", 1'b0, 0, 0, 2, 1'b0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_line_ctrl.md
# vector_line_ctrl

Sequences the X/Y vector DAC datapath for the 255x255 vector display: accepts one line-segment command at a time over a valid/ready handshake, blanks the beam and waits for the deflection to settle at the start point, then walks the segment point-by-point (Bresenham), holding each point for a fixed dwell with the beam on. It sits between the display-list/command source and the DAC output stage. Pin-level bit permutation of `dac_x`/`dac_y` is applied downstream, not here.

## Interface
Parameters:
- `DAC_WIDTH`, 8: code width of X and Y. The logic is specified for 8.
- `SETTLE_CYCLES`, 16: blanked dwell after a repositioning move. Must be ≥1.
- `STEP_DIV`, 4: clock cycles each drawn point is held. Must be ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_x0`, `cmd_y0` in 8 each: segment start, in the range 0..255.
- `cmd_x1`, `cmd_y1` in 8 each: segment end, in the range 0..255.
- `dac_x`, `dac_y` out 8 each: registered binary deflection codes.
- `beam_on` out 1: registered; beam is unblanked when high.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a segment completes.

## Operation
- **States:** IDLE, MOVE, DRAW, FINISH.
- **IDLE:** `cmd_ready`=1. On `cmd_valid & cmd_ready`, capture all four coordinates.
  - If `{cmd_x0,cmd_y0}` equals the current `{dac_x,dac_y}`, go to DRAW.
  - Otherwise go to MOVE.
  - Command inputs are ignored outside IDLE.
- **MOVE:** `dac_x/y` = start point, `beam_on`=0. Stay exactly `SETTLE_CYCLES` cycles, then go to DRAW.
- **DRAW:** `beam_on`=1. Emit points starting at (x0,y0); each point is held `STEP_DIV` cycles.
  - Setup: dx=|x1−x0|, dy=−|y1−y0|, sx/sy=±1 toward the end point, err=dx+dy.
  - `err` is 10-bit signed; e2=2·err is 11-bit signed.
  - Per step: if e2≥dy then err+=dy, x+=sx. If e2≤dx then err+=dx, y+=sy. Both updates use the pre-step e2.
  - After the dwell of the point equal to (x1,y1), go to FINISH.
  - Point count N=max(dx,|dy|)+1. A zero-length segment gives N=1.
  - Coordinates are monotonic toward the end point, so no wrap-around can occur.
- **FINISH:** one cycle with `beam_on`=0, `done`=1, `dac_x/y` held at the end point. Next state is IDLE.
- **Position retention:** `dac_x/y` keep the last end point in IDLE. This lets a chained segment skip MOVE.
- **Reset (any time, including mid-segment):**
  - State returns to IDLE and the captured command is discarded.
  - `dac_x`=0, `dac_y`=0, `beam_on`=0, `done`=0, `busy`=0, `cmd_ready`=1.
  - After reset, a command starting at (0,0) skips MOVE.

## Timing
- Accept edge is E. The MOVE/DRAW entry state and its outputs are visible in cycle E+1.
- Cycles from acceptance until `cmd_ready` is high again:
  - With MOVE: `SETTLE_CYCLES` + N·`STEP_DIV` + 2.
  - Without MOVE: N·`STEP_DIV` + 2.
- `done` is high in the second-to-last of those cycles. `cmd_ready` is high in the last.
- `beam_on` is high for exactly N·`STEP_DIV` cycles per segment. It is never high while `dac_x/y` change outside a DRAW step.
- `dac_x/y` change only on the clock edge that ends a dwell.
- With `cmd_valid` held high continuously, exactly one command is accepted per IDLE visit. There are no back-to-back accepts without the intervening IDLE cycle.

All test-plan values below use defaults: SETTLE=16, STEP_DIV=4.

## Test plan
- **Horizontal segment:** previous end (0,0); command (10,20)→(13,20).
  - MOVE for 16 cycles at (10,20) with `beam_on`=0.
  - Then x=10,11,12,13, each held 4 cycles, y=20, `beam_on`=1 for 16 cycles.
  - `done` pulses at E+33; `cmd_ready` returns at E+34.
- **Steep segment right after reset:** (0,0)→(2,5).
  - MOVE is skipped.
  - Points (0,0),(0,1),(1,2),(1,3),(2,4),(2,5), 4 cycles each.
  - `cmd_ready` returns at E+26.
- **Reverse direction:** (200,100)→(197,100).
  - x=200,199,198,197 with y constant.
  - `dac_x/y` never leave the range 197..200.
- **Zero length:** from (197,100), command (255,255)→(255,255).
  - 16-cycle MOVE, then one point held 4 cycles.
  - `done` at E+21; `cmd_ready` at E+22.
- **Chaining:** `cmd_valid` held high with (5,5)→(8,5) then (8,5)→(8,7).
  - The second segment skips MOVE.
  - `cmd_ready` is low throughout both busy periods; exactly two accepts occur.
- **Reset mid-DRAW:** assert `rst_n`=0 during the third point.
  - Immediately `dac_x`=`dac_y`=0, `beam_on`=0, `busy`=0, `cmd_ready`=1, and `done` stays 0.
  - After release, a new command is accepted and the discarded segment is not resumed.
